// File: rtl/sb_fpga_rx_reader_if.sv
// AXI4 manager bundle (512b data, 64b address) between one RX queue reader and its crossbar slot.
interface sb_fpga_rx_reader_if #(parameter int ID_WIDTH = 16);
  logic [ID_WIDTH-1:0] awid;
  logic [63:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [511:0]        wdata;
  logic [63:0]         wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] arid;
  logic [63:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [511:0]        rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/sb_fpga_rx_reader.sv
// Switchboard RX queue consumer: polls the host ring head, fetches 64B slots, streams them out,
// writes the tail back. One AXI transaction in flight at most; stream output holds until ready.
module sb_fpga_rx_reader #(
  parameter int ID_WIDTH   = 16,
  parameter int DW         = 416,
  parameter int POLL_DELAY = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [63:0]       cfg_base_addr,
  input  logic [31:0]       cfg_capacity,
  output logic              status_idle,
  output logic [DW-1:0]     data,
  output logic [31:0]       dest,
  output logic              last,
  output logic              valid,
  input  logic              ready,
  sb_fpga_rx_reader_if.master m_axi
);
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_HEAD_AR = 4'd1;
  localparam logic [3:0] S_HEAD_R  = 4'd2;
  localparam logic [3:0] S_WAIT    = 4'd3;
  localparam logic [3:0] S_PKT_AR  = 4'd4;
  localparam logic [3:0] S_PKT_R   = 4'd5;
  localparam logic [3:0] S_OUT     = 4'd6;
  localparam logic [3:0] S_TAIL_W  = 4'd7;
  localparam logic [3:0] S_B       = 4'd8;

  localparam int CW = $clog2(POLL_DELAY + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(POLL_DELAY - 1);

  logic [3:0]    state;
  logic [31:0]   tail;
  logic [31:0]   head_cache;
  logic [CW-1:0] wait_cnt;
  logic          aw_pend;
  logic          w_pend;

  logic        cap_ok;
  logic        pkt_avail;
  logic [31:0] tail_inc;
  logic [31:0] rhead;
  logic        aw_done;
  logic        w_done;

  assign cap_ok    = cfg_capacity >= 32'd2;
  // A cached head outside the ring is never trusted as a fill level.
  assign pkt_avail = (tail != head_cache) && (head_cache < cfg_capacity);
  assign tail_inc  = tail + 32'd1;
  assign rhead     = m_axi.rdata[31:0];
  assign aw_done   = !aw_pend || m_axi.awready;
  assign w_done    = !w_pend || m_axi.wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tail       <= '0;
      head_cache <= '0;
      wait_cnt   <= '0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
      data       <= '0;
      dest       <= '0;
      last       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && cap_ok) state <= pkt_avail ? S_PKT_AR : S_HEAD_AR;
        end
        S_HEAD_AR: begin
          if (m_axi.arready) state <= S_HEAD_R;
        end
        S_HEAD_R: begin
          if (m_axi.rvalid) begin
            head_cache <= rhead;
            if (rhead == tail || rhead >= cfg_capacity) begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end else begin
              state <= S_PKT_AR;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_IDLE;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        S_PKT_AR: begin
          if (m_axi.arready) state <= S_PKT_R;
        end
        S_PKT_R: begin
          if (m_axi.rvalid) begin
            data  <= m_axi.rdata[DW-1:0];
            dest  <= m_axi.rdata[447:416];
            last  <= m_axi.rdata[448];
            state <= S_OUT;
          end
        end
        S_OUT: begin
          if (ready) begin
            tail    <= (tail_inc == cfg_capacity) ? 32'd0 : tail_inc;
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
            state   <= S_TAIL_W;
          end
        end
        S_TAIL_W: begin
          if (m_axi.awready) aw_pend <= 1'b0;
          if (m_axi.wready)  w_pend  <= 1'b0;
          if (aw_done && w_done) state <= S_B;
        end
        S_B: begin
          if (m_axi.bvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign valid       = (state == S_OUT);
  assign status_idle = (state == S_IDLE) || (state == S_WAIT);

  assign m_axi.arid    = '0;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = 3'd6;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arvalid = (state == S_HEAD_AR) || (state == S_PKT_AR);
  assign m_axi.araddr  = (state == S_PKT_AR) ? cfg_base_addr + 64'd128 + {26'd0, tail, 6'd0}
                                             : cfg_base_addr;
  // Idle states also sink stray R/B beats left over from an aborted sequence.
  assign m_axi.rready  = (state == S_HEAD_R) || (state == S_PKT_R) ||
                         (state == S_IDLE) || (state == S_WAIT);
  assign m_axi.bready  = (state == S_B) || (state == S_IDLE) || (state == S_WAIT);

  assign m_axi.awid    = '0;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = 3'd6;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awvalid = aw_pend;
  assign m_axi.awaddr  = cfg_base_addr + 64'd64;
  assign m_axi.wvalid  = w_pend;
  assign m_axi.wdata   = {480'd0, tail};
  assign m_axi.wstrb   = 64'hF;
  assign m_axi.wlast   = 1'b1;
endmodule

// File: tb/tb_sb_fpga_rx_reader.sv
// Bench for sb_fpga_rx_reader: host-memory/AXI subordinate model plus a ring-level reference model.
module tb_sb_fpga_rx_reader;
  localparam int DW = 416;
  localparam int PD = 16;
  localparam logic [63:0] BASE = 64'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, en, status_idle, last, valid, ready;
  logic [63:0]   cfg_base_addr;
  logic [31:0]   cfg_capacity, dest;
  logic [DW-1:0] data;

  sb_fpga_rx_reader_if #(.ID_WIDTH(16)) ax ();

  sb_fpga_rx_reader #(.ID_WIDTH(16), .DW(DW), .POLL_DELAY(PD)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_base_addr(cfg_base_addr), .cfg_capacity(cfg_capacity),
    .status_idle(status_idle), .data(data), .dest(dest), .last(last), .valid(valid), .ready(ready),
    .m_axi(ax)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Host memory and ring-level reference model
  logic [511:0] slot_mem [0:15];
  logic [31:0]  host_head;
  int           mtail, mcap;
  logic [511:0] exp_pkt[$];
  int           exp_tail[$];

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Host publishes a new head: every slot from the model tail up to it must come out, in order.
  function automatic void set_head(input int h);
    host_head = h;
    if (h < mcap) begin
      while (mtail != h) begin
        exp_pkt.push_back(slot_mem[mtail]);
        mtail = (mtail + 1) % mcap;
        exp_tail.push_back(mtail);
      end
    end
  endfunction

  // Observation logs and subordinate state
  logic [63:0]  ar_log[$], slot_ar_log[$], aw_log[$];
  int           ar_cyc[$], wd_log[$];
  int           cyc = 0, ar_cnt = 0, slot_ar_cnt = 0, r_cnt = 0, b_cnt = 0, pkt_cnt = 0, aw_cnt = 0;
  bit           valid_seen = 0;
  logic [511:0] rq_dat[$];
  int           rq_t[$];
  int           rd_out = 0, b_t = 0;
  bit           aw_done = 0, w_done = 0, b_pend = 0;
  int           ready_mode = 1, r_lat_fix = -1;
  bit           slow = 0;

  initial begin
    bit ar_f, r_f, aw_f, w_f, b_f, s_f, rst_s, arok, awok;
    logic [63:0]   araddr_s, awaddr_s, off;
    logic [511:0]  wd_s, rd, ep;
    logic [63:0]   wstrb_s;
    logic          wlast_s, last_s;
    logic [DW-1:0] data_s;
    logic [31:0]   dest_s;
    int            et;
    ax.arready = 0; ax.rvalid = 0; ax.rdata = '0; ax.rid = '0; ax.rresp = '0; ax.rlast = 1;
    ax.awready = 0; ax.wready = 0; ax.bvalid = 0; ax.bid = '0; ax.bresp = '0; ready = 0;
    forever begin
      @(negedge clk);
      rst_s = reset;
      ar_f = ax.arvalid && ax.arready;  r_f = ax.rvalid && ax.rready;
      aw_f = ax.awvalid && ax.awready;  w_f = ax.wvalid && ax.wready;
      b_f  = ax.bvalid && ax.bready;    s_f = valid && ready;
      araddr_s = ax.araddr; awaddr_s = ax.awaddr; wd_s = ax.wdata; wstrb_s = ax.wstrb; wlast_s = ax.wlast;
      arok = (ax.arid == 0) && (ax.arlen == 0) && (ax.arsize == 3'd6);
      awok = (ax.awid == 0) && (ax.awlen == 0) && (ax.awsize == 3'd6);
      data_s = data; dest_s = dest; last_s = last;
      if (valid && !rst_s) valid_seen = 1;
      @(posedge clk); #1;
      cyc++;
      if (!rst_s) begin
        if (r_f) begin
          void'(rq_dat.pop_front()); void'(rq_t.pop_front()); rd_out--; r_cnt++;
        end
        if (ar_f) begin
          chk(rd_out == 0 && !b_pend && !aw_done && !w_done, "single_outstanding_ar", rd_out, 0);
          chk(arok, "ar_attrs", araddr_s, araddr_s);
          ar_log.push_back(araddr_s); ar_cyc.push_back(cyc); ar_cnt++;
          if (araddr_s == cfg_base_addr) begin
            rd = rand512(); rd[31:0] = host_head;
          end else begin
            off = (araddr_s - cfg_base_addr - 64'd128) >> 6;
            rd = slot_mem[off[3:0]];
            slot_ar_log.push_back(araddr_s); slot_ar_cnt++;
          end
          rq_dat.push_back(rd);
          rq_t.push_back(cyc + ((r_lat_fix >= 0) ? r_lat_fix : (slow ? $urandom_range(0, 3) : 0)));
          rd_out++;
        end
        if (aw_f) begin
          chk(rd_out == 0 && awok, "aw_attrs_single_outstanding", rd_out, 0);
          aw_log.push_back(awaddr_s); aw_done = 1; aw_cnt++;
        end
        if (w_f) begin
          if (exp_tail.size() == 0) chk(0, "unexpected_tail_write", wd_s[63:0], 0);
          else begin
            et = exp_tail.pop_front();
            chk(wd_s[31:0] == et && wd_s[511:32] == '0 && wstrb_s == 64'hF && wlast_s,
                "tail_wdata", wd_s[63:0], et);
          end
          wd_log.push_back(int'(wd_s[31:0])); w_done = 1;
        end
        if (b_f) begin b_pend = 0; b_cnt++; end
        if (aw_done && w_done) begin
          aw_done = 0; w_done = 0; b_pend = 1; b_t = cyc + (slow ? $urandom_range(0, 3) : 0);
        end
        if (s_f) begin
          pkt_cnt++;
          if (exp_pkt.size() == 0) chk(0, "unexpected_packet", {dest_s, data_s[31:0]}, 0);
          else begin
            ep = exp_pkt.pop_front();
            chk(data_s == ep[DW-1:0] && dest_s == ep[447:416] && last_s == ep[448], "packet_content",
                {dest_s, data_s[31:0]}, {ep[447:416], ep[31:0]});
          end
        end
      end
      ax.rvalid  = (rq_t.size() > 0) && (rq_t[0] <= cyc);
      ax.rdata   = (rq_dat.size() > 0) ? rq_dat[0] : '0;
      ax.bvalid  = b_pend && (cyc >= b_t);
      ax.arready = slow ? ($urandom_range(0, 2) != 0) : 1'b1;
      ax.awready = slow ? ($urandom_range(0, 2) != 0) : 1'b1;
      ax.wready  = slow ? ($urandom_range(0, 2) != 0) : 1'b1;
      ready      = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while (!(exp_pkt.size() == 0 && exp_tail.size() == 0 && !b_pend && !aw_done && !w_done &&
             status_idle && rd_out == 0) && n < budget) begin
      @(negedge clk); n++;
    end
    chk(n < budget, nm, n, budget);
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int n = 0;
    while (!valid && n < budget) begin @(negedge clk); n++; end
    chk(n < budget, nm, n, budget);
  endtask

  task automatic quiesce_reset();
    int n = 0;
    en = 0;
    while (!(status_idle && rd_out == 0 && !b_pend && !aw_done && !w_done) && n < 500) begin
      @(negedge clk); n++;
    end
    chk(n < 500, "quiesce", n, 500);
    reset = 1; repeat (3) @(negedge clk); reset = 0;
    exp_pkt.delete(); exp_tail.delete(); mtail = 0; host_head = 0;
  endtask

  typedef struct { int head; int exp_pkts; int exp_tail; } vec_t;
  vec_t vt[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, a0, p0, r0, b0, n, h, kk;
    bit flag, stable, no_aw;
    logic [DW-1:0] d0; logic [31:0] t0; logic l0;
    logic [511:0] s;

    // cap=4 ring starting from tail 0; tail column is the last value written back
    vt[0] = '{head: 2, exp_pkts: 2, exp_tail: 2};
    vt[1] = '{head: 0, exp_pkts: 2, exp_tail: 0};
    vt[2] = '{head: 3, exp_pkts: 3, exp_tail: 3};
    vt[3] = '{head: 7, exp_pkts: 0, exp_tail: 3};
    vt[4] = '{head: 1, exp_pkts: 2, exp_tail: 1};

    for (int i = 0; i < 16; i++) slot_mem[i] = rand512();
    reset = 1; en = 0; cfg_base_addr = BASE; cfg_capacity = 4; mcap = 4; mtail = 0; host_head = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk(valid == 0, "reset_valid", valid, 0);
    chk(ax.arvalid == 0, "reset_arvalid", ax.arvalid, 0);
    chk(ax.awvalid == 0 && ax.wvalid == 0, "reset_awvalid", ax.awvalid, 0);
    chk(status_idle == 1, "reset_status_idle", status_idle, 1);
    reset = 0;

    // Empty ring: only head polls, spaced by the poll delay
    ar_log.delete(); ar_cyc.delete(); slot_ar_log.delete(); valid_seen = 0; en = 1;
    repeat (120) @(negedge clk);
    chk(ar_log.size() >= 3, "empty_polls_repeat", ar_log.size(), 3);
    flag = 1;
    foreach (ar_log[i]) if (ar_log[i] != BASE) flag = 0;
    chk(flag, "empty_poll_addr", ar_log.size(), BASE);
    n = 1000;
    for (int i = 1; i < ar_cyc.size(); i++) if (ar_cyc[i] - ar_cyc[i-1] < n) n = ar_cyc[i] - ar_cyc[i-1];
    chk(n >= PD, "empty_poll_gap", n, PD);
    chk(slot_ar_log.size() == 0, "empty_no_slot_ar", slot_ar_log.size(), 0);
    chk(valid_seen == 0, "empty_no_valid", valid_seen, 0);

    // Two packets A, B
    s = rand512(); s[447:416] = 32'd5; s[448] = 1'b0; slot_mem[0] = s;
    s = rand512(); s[448] = 1'b1; slot_mem[1] = s;
    aw_log.delete(); wd_log.delete(); p0 = pkt_cnt;
    set_head(2);
    wait_drain(1000, "two_pkt_drain");
    chk(pkt_cnt - p0 == 2, "two_pkt_count", pkt_cnt - p0, 2);
    chk(slot_ar_log.size() == 2, "two_pkt_ar_count", slot_ar_log.size(), 2);
    if (slot_ar_log.size() == 2) begin
      chk(slot_ar_log[0] == 64'h1000_0080, "slot0_addr", slot_ar_log[0], 64'h1000_0080);
      chk(slot_ar_log[1] == 64'h1000_00C0, "slot1_addr", slot_ar_log[1], 64'h1000_00C0);
    end
    flag = (aw_log.size() == 2);
    foreach (aw_log[i]) if (aw_log[i] != 64'h1000_0040) flag = 0;
    chk(flag, "tail_awaddr", aw_log.size(), 64'h1000_0040);
    if (wd_log.size() == 2) begin
      chk(wd_log[0] == 1, "tail_wr_first", wd_log[0], 1);
      chk(wd_log[1] == 2, "tail_wr_second", wd_log[1], 2);
    end else chk(0, "tail_wr_count", wd_log.size(), 2);

    // Wrap from tail 3 back to 0
    set_head(3);
    wait_drain(1000, "to_tail3_drain");
    ar_log.delete(); slot_ar_log.delete(); wd_log.delete();
    set_head(0);
    wait_drain(1000, "wrap_drain");
    chk(slot_ar_log.size() == 1 && slot_ar_log[0] == 64'h1000_0140, "wrap_slot_addr",
        (slot_ar_log.size() > 0) ? slot_ar_log[0] : 64'd0, 64'h1000_0140);
    chk(wd_log.size() == 1 && wd_log[0] == 0, "wrap_tail_wr",
        (wd_log.size() > 0) ? wd_log[0] : -1, 0);
    kk = -1;
    foreach (ar_log[i]) if (ar_log[i] == 64'h1000_0140) kk = i;
    n = 0;
    while (ar_log.size() <= kk + 1 && n < 200) begin @(negedge clk); n++; end
    chk(kk >= 0 && ar_log.size() > kk + 1 && ar_log[kk+1] == BASE, "wrap_next_ar_is_poll",
        (kk >= 0 && ar_log.size() > kk + 1) ? ar_log[kk+1] : 64'd0, BASE);

    // Backpressure: output held 50 cycles, no tail write until the handshake
    ready_mode = 0; slot_mem[0] = rand512();
    set_head(1);
    wait_valid(1000, "bp_valid");
    d0 = data; t0 = dest; l0 = last; stable = 1; no_aw = 1; a0 = aw_cnt;
    repeat (50) begin
      @(negedge clk);
      if (!valid || data != d0 || dest != t0 || last != l0) stable = 0;
      if (ax.awvalid || ax.wvalid) no_aw = 0;
    end
    chk(stable, "bp_output_stable", {dest, data[31:0]}, {t0, d0[31:0]});
    chk(no_aw && aw_cnt == a0, "bp_no_aw", aw_cnt - a0, 0);
    p0 = pkt_cnt; ready_mode = 1; n = 0;
    while (pkt_cnt == p0 && n < 20) begin @(negedge clk); n++; end
    chk(pkt_cnt == p0 + 1 && ax.awvalid && ax.wvalid, "bp_aw_w_after_handshake",
        {ax.awvalid, ax.wvalid}, 2'b11);
    wait_drain(1000, "bp_drain");

    // en dropped while a packet is presented: packet and writeback still complete
    ready_mode = 0; slot_mem[1] = rand512(); p0 = pkt_cnt; b0 = b_cnt;
    set_head(2);
    wait_valid(1000, "en_off_valid");
    en = 0; ready_mode = 1;
    wait_drain(1000, "en_off_drain");
    chk(pkt_cnt == p0 + 1 && b_cnt == b0 + 1, "en_off_completes", pkt_cnt - p0, 1);
    a0 = ar_cnt;
    repeat (100) @(negedge clk);
    chk(ar_cnt == a0, "en_off_no_ar", ar_cnt - a0, 0);
    chk(status_idle == 1, "en_off_idle", status_idle, 1);

    // Reset while waiting for a slot beat; the late beat is swallowed
    r_lat_fix = 3; slot_mem[2] = rand512(); k0 = slot_ar_cnt;
    set_head(3); en = 1; n = 0;
    while (slot_ar_cnt == k0 && n < 500) begin @(negedge clk); n++; end
    chk(slot_ar_cnt > k0, "rst_pkt_ar_seen", slot_ar_cnt - k0, 1);
    r0 = r_cnt; reset = 1; en = 0;
    @(negedge clk);
    reset = 0; exp_pkt.delete(); exp_tail.delete(); mtail = 0; host_head = 0; valid_seen = 0;
    repeat (12) @(negedge clk);
    chk(r_cnt == r0 + 1 && rd_out == 0, "rst_stray_r_accepted", r_cnt - r0, 1);
    chk(valid_seen == 0, "rst_no_valid", valid_seen, 0);
    chk(status_idle == 1, "rst_status_idle", status_idle, 1);
    r_lat_fix = -1;

    // Table-driven ring sequence with random AXI latency and stream backpressure
    slow = 1; ready_mode = 2; en = 1; wd_log.delete();
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < mcap; j++) slot_mem[j] = rand512();
      p0 = pkt_cnt;
      set_head(vt[i].head);
      wait_drain(2000, "table_drain");
      repeat (40) @(negedge clk);
      chk(pkt_cnt - p0 == vt[i].exp_pkts, "table_pkt_count", pkt_cnt - p0, vt[i].exp_pkts);
      chk(wd_log.size() > 0 && wd_log[$] == vt[i].exp_tail, "table_tail",
          (wd_log.size() > 0) ? wd_log[$] : -1, vt[i].exp_tail);
    end

    // Random capacities and head advances against the reference model
    quiesce_reset();
    mcap = $urandom_range(2, 8); cfg_capacity = mcap; en = 1;
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j < mcap; j++) slot_mem[j] = rand512();
      kk = $urandom_range(0, mcap);
      h = (kk == mcap) ? mcap + $urandom_range(0, 5) : (mtail + kk) % mcap;
      set_head(h);
      wait_drain(3000, "random_drain");
    end
    repeat (40) @(negedge clk);
    chk(exp_pkt.size() == 0 && exp_tail.size() == 0, "random_all_consumed", exp_pkt.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
